// File: rtl/selector_seq_pkg.sv
// Shared definitions for the selector sequencer.
//   state_t        : sequencer FSM states
//   VAL_*          : decode table constants (7 bits wide; the largest is 72)
//   decode_t       : {mapped, value} result of one table lookup
//   UNMAPPED       : lookup result for selectors outside the table
package selector_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DEC_WIDTH = 7;

  localparam logic [DEC_WIDTH-1:0] VAL_SEL0   = 7'd17;
  localparam logic [DEC_WIDTH-1:0] VAL_SEL1   = 7'd22;
  localparam logic [DEC_WIDTH-1:0] VAL_SEL2   = 7'd30;
  localparam logic [DEC_WIDTH-1:0] VAL_SEL3_6 = 7'd72;

  typedef struct packed {
    logic                 mapped;
    logic [DEC_WIDTH-1:0] value;
  } decode_t;

  localparam decode_t UNMAPPED = '{mapped: 1'b0, value: '0};

endpackage

// File: rtl/selector_sequencer_decode.sv
// Combinational selector decode table.
// Ports:
//   sel    in   SEL_WIDTH  selector to look up
//   mapped out  1          selector has a table entry
//   value  out  WIDTH      table value, zero-extended (0 when unmapped)
module selector_sequencer_decode
  import selector_seq_pkg::*;
#(
  parameter int SEL_WIDTH = 3,
  parameter int WIDTH     = 8
) (
  input  logic [SEL_WIDTH-1:0] sel,
  output logic                 mapped,
  output logic [WIDTH-1:0]     value
);

  decode_t        dec;
  logic    [31:0] sel_ext;

  assign sel_ext = 32'(sel);

  always_comb begin
    // NOTE: default first so every path assigns dec; otherwise a latch is inferred.
    dec = UNMAPPED;
    case (sel_ext)
      0:          dec = '{mapped: 1'b1, value: VAL_SEL0};
      1:          dec = '{mapped: 1'b1, value: VAL_SEL1};
      2:          dec = '{mapped: 1'b1, value: VAL_SEL2};
      3, 4, 5, 6: dec = '{mapped: 1'b1, value: VAL_SEL3_6};
      default:    dec = UNMAPPED;
    endcase
  end

  assign mapped = dec.mapped;
  assign value  = WIDTH'(dec.value);

endmodule

// File: rtl/selector_sequencer.sv
// Selector sequencer: accepts {start selector, step count} over valid/ready,
// then walks the selector one step per clock, decoding each selector and
// writing the result round-robin into CHANNELS output registers.
// Ports:
//   clock     in   1                    clock, all state on posedge
//   reset     in   1                    synchronous, active-high
//   in_valid  in   1                    command valid
//   in_ready  out  1                    high in IDLE; accept = in_valid && in_ready
//   in_sel    in   SEL_WIDTH            start selector
//   in_count  in   clog2(MAX_COUNT+1)   step count, clamped to MAX_COUNT
//   out_regs  out  CHANNELS*WIDTH       output registers, channel 0 in LSBs
//   busy      out  1                    high while stepping
//   done      out  1                    one-cycle pulse at command end
//   err       out  1                    an unmapped selector was hit this command
module selector_sequencer
  import selector_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 3,
  parameter int CHANNELS  = 2,
  parameter int MAX_COUNT = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_WIDTH-1:0]          in_sel,
  input  logic [$clog2(MAX_COUNT+1)-1:0] in_count,
  output logic [CHANNELS*WIDTH-1:0]     out_regs,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int CW   = $clog2(MAX_COUNT + 1);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t               state;
  logic [SEL_WIDTH-1:0] cur_sel;   // sel + step, wraps naturally
  logic [CW-1:0]        count;
  logic [CW-1:0]        step;
  logic [CH_W-1:0]      ch;        // step mod CHANNELS, kept as its own counter
  logic [WIDTH-1:0]     regs [CHANNELS];

  logic                 dec_mapped;
  logic [WIDTH-1:0]     dec_value;
  logic [CW-1:0]        count_clamped;

  assign count_clamped = (in_count > CW'(MAX_COUNT)) ? CW'(MAX_COUNT) : in_count;

  selector_sequencer_decode #(
    .SEL_WIDTH (SEL_WIDTH),
    .WIDTH     (WIDTH)
  ) u_decode (
    .sel    (cur_sel),
    .mapped (dec_mapped),
    .value  (dec_value)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cur_sel  <= '0;
      count    <= '0;
      step     <= '0;
      ch       <= '0;
      // NOTE: these are config registers that must read zero after reset,
      // so unlike a RAM array they are reset element by element.
      for (int i = 0; i < CHANNELS; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking throughout so every branch sees pre-edge values.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_valid) begin
            cur_sel  <= in_sel;
            count    <= count_clamped;
            step     <= '0;
            ch       <= '0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            if (count_clamped != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (dec_mapped) regs[ch] <= dec_value;
          else            err      <= 1'b1;
          cur_sel <= cur_sel + 1'b1;
          step    <= step + 1'b1;
          ch      <= (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + 1'b1;
          if (step == count - CW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign out_regs[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_selector_sequencer.sv
module tb_selector_sequencer;

  localparam int WIDTH     = 8;
  localparam int SEL_WIDTH = 3;
  localparam int CHANNELS  = 2;
  localparam int MAX_COUNT = 8;
  localparam int CW        = $clog2(MAX_COUNT + 1);
  localparam int NSEL      = 1 << SEL_WIDTH;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_WIDTH-1:0]      in_sel;
  logic [CW-1:0]             in_count;
  logic [CHANNELS*WIDTH-1:0] out_regs;
  logic                      busy;
  logic                      done;
  logic                      err;

  int tests = 0;
  int fails = 0;

  // Reference state: table lookups by selector, -1 meaning no entry.
  int tbl [NSEL] = '{17, 22, 30, 72, 72, 72, 72, -1};
  int model_regs [CHANNELS];
  bit model_err;

  selector_sequencer #(
    .WIDTH     (WIDTH),
    .SEL_WIDTH (SEL_WIDTH),
    .CHANNELS  (CHANNELS),
    .MAX_COUNT (MAX_COUNT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_count (in_count),
    .out_regs (out_regs),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CHANNELS*WIDTH-1:0] model_packed();
    logic [CHANNELS*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < CHANNELS; i++) v[i*WIDTH +: WIDTH] = WIDTH'(model_regs[i]);
    return v;
  endfunction

  // Issue one command and follow it cycle by cycle to the end of its done pulse.
  task automatic run_cmd(input int sel, input int cnt, input bit hold, input string tag);
    int eff;
    int s;
    eff = (cnt > MAX_COUNT) ? MAX_COUNT : cnt;
    @(negedge clock);
    check({tag, "_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_sel   = SEL_WIDTH'(sel);
    in_count = CW'(cnt);
    @(negedge clock);
    model_err = 1'b0;
    if (!hold) in_valid = 1'b0;
    for (int cyc = 0; cyc <= eff; cyc++) begin
      if (cyc > 0) begin
        @(negedge clock);
        s = (sel + cyc - 1) % NSEL;
        if (tbl[s] < 0) model_err = 1'b1;
        else            model_regs[(cyc - 1) % CHANNELS] = tbl[s];
      end
      if (hold) begin
        in_sel   = SEL_WIDTH'($urandom);
        in_count = CW'($urandom);
        if (cyc == eff) in_valid = 1'b0;
      end
      check({tag, "_busy"},  64'(busy),     64'(cyc < eff));
      check({tag, "_done"},  64'(done),     64'(cyc == eff));
      check({tag, "_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_regs"},  64'(out_regs), 64'(model_packed()));
      check({tag, "_err"},   64'(err),      64'(model_err));
    end
    @(negedge clock);
    check({tag, "_done_end"},  64'(done),     64'd0);
    check({tag, "_ready_end"}, 64'(in_ready), 64'd1);
    check({tag, "_busy_end"},  64'(busy),     64'd0);
  endtask

  initial begin
    for (int i = 0; i < CHANNELS; i++) model_regs[i] = 0;
    model_err = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sel   = '0;
    in_count = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_regs",  64'(out_regs), 64'd0);
    check("rst_busy",  64'(busy),     64'd0);
    check("rst_done",  64'(done),     64'd0);
    check("rst_err",   64'(err),      64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // sel=0, count=3: ch0=17, ch1=22, ch0=30
    run_cmd(0, 3, 1'b0, "t_sel0");
    check("t_sel0_final", 64'(out_regs), 64'h161E);
    check("t_sel0_err",   64'(err),      64'd0);

    // sel=6, count=3: ch0=72, s=7 unmapped, ch0=17
    run_cmd(6, 3, 1'b0, "t_sel6");
    check("t_sel6_final", 64'(out_regs), 64'h1611);
    repeat (3) begin
      @(negedge clock);
      check("t_sel6_err_sticky", 64'(err), 64'd1);
    end

    // count=0: done right after accept, registers untouched, err cleared by accept
    run_cmd(2, 0, 1'b0, "t_cnt0");
    check("t_cnt0_regs", 64'(out_regs), 64'h1611);
    check("t_cnt0_err",  64'(err),      64'd0);

    // Over-range count clamps to MAX_COUNT
    run_cmd(1, 15, 1'b0, "t_clamp");

    // Command held valid with changing selector during RUN/DONE
    run_cmd(5, 4, 1'b1, "t_hold");

    // Reset after the first RUN write of a count=4 command
    @(negedge clock);
    in_valid = 1'b1;
    in_sel   = 3'd0;
    in_count = CW'(4);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    model_regs[0] = 17;
    check("t_rst_first_write", 64'(out_regs), 64'(model_packed()));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < CHANNELS; i++) model_regs[i] = 0;
    model_err = 1'b0;
    check("t_rst_regs",  64'(out_regs), 64'd0);
    check("t_rst_busy",  64'(busy),     64'd0);
    check("t_rst_done",  64'(done),     64'd0);
    check("t_rst_err",   64'(err),      64'd0);
    check("t_rst_ready", 64'(in_ready), 64'd1);
    repeat (6) begin
      @(negedge clock);
      check("t_rst_no_done", 64'(done), 64'd0);
      check("t_rst_no_busy", 64'(busy), 64'd0);
    end

    // Selector wrap: 7 -> 0
    run_cmd(7, 2, 1'b0, "t_wrap");

    // Randomized commands against the reference model
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run_cmd(int'($urandom_range(0, NSEL - 1)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), "t_rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
